// File: rtl/axis_slave.sv
// AXI-Stream sink: buffers {tlast,tdata} beats in a FIFO for a local consumer, tracks beat position and counts packets.
// Optional feature macro: AXIS_SLAVE_LEN_CHECK_EN enables packet length checking (len_err / err_count).
module axis_slave #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 8,
   parameter int PKT_LEN = 4,
   parameter int CNT_W   = 16
) (
   input  logic                         s_axis_aclk,
   input  logic                         s_axis_arst,
   input  logic [DATA_W-1:0]            s_axis_tdata,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [DATA_W-1:0]            data_out,
   output logic                         data_last,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic [CNT_W-1:0]             pkt_count,
   output logic [$clog2(PKT_LEN+1)-1:0] beat_idx,
   output logic                         len_err,
   output logic [CNT_W-1:0]             err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(PKT_LEN+1);

   // Handshakes: a beat moves on s_axis_tvalid && s_axis_tready, a pop on data_valid && data_ready,
   // both sampled at the rising edge; neither valid ever depends on its ready.
   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
   state_t state, state_next;

   logic [DATA_W:0] mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr, wr_next, rd_next;
   logic            push, pop, empty, full_next;
   logic [DATA_W:0] head;
   logic [BW:0]     beat_plus;
   logic [BW-1:0]   beat_next;
   logic            pkt_inc;
`ifdef AXIS_SLAVE_LEN_CHECK_EN
   logic            err_set;
`endif

   assign push      = s_axis_tvalid && s_axis_tready;
   assign empty     = (wr_ptr == rd_ptr);
   assign pop       = !empty && data_ready;
   assign wr_next   = wr_ptr + (AW+1)'(push);
   assign rd_next   = rd_ptr + (AW+1)'(pop);
   assign full_next = (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);

   assign head       = mem[rd_ptr[AW-1:0]];
   assign data_valid = !empty;
   assign data_out   = empty ? '0 : head[DATA_W-1:0];
   assign data_last  = empty ? 1'b0 : head[DATA_W];

   always_ff @(posedge s_axis_aclk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
   end

   // tready looks one edge ahead so it drops in the same cycle the FIFO fills.
   always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
      if (s_axis_arst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         s_axis_tready <= 1'b0;
      end else begin
         wr_ptr        <= wr_next;
         rd_ptr        <= rd_next;
         s_axis_tready <= !full_next;
      end
   end

   assign beat_plus = {1'b0, beat_idx} + (BW+1)'(1);

   always_comb begin
      state_next = state;
      beat_next  = beat_idx;
      pkt_inc    = 1'b0;
`ifdef AXIS_SLAVE_LEN_CHECK_EN
      err_set    = 1'b0;
      if (push) begin
         if (s_axis_tlast || beat_plus == (BW+1)'(PKT_LEN)) begin
            // Both a correct tlast and a wrong-length boundary close the packet.
            state_next = IDLE;
            beat_next  = '0;
            if (s_axis_tlast && beat_plus == (BW+1)'(PKT_LEN)) pkt_inc = 1'b1;
            else                                                err_set = 1'b1;
         end else begin
            state_next = RECV;
            beat_next  = beat_plus[BW-1:0];
         end
      end
`else
      if (push) begin
         if (s_axis_tlast) begin
            state_next = IDLE;
            beat_next  = '0;
            pkt_inc    = 1'b1;
         end else begin
            state_next = RECV;
            beat_next  = beat_plus[BW] ? '1 : beat_plus[BW-1:0];
         end
      end
`endif
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
      if (s_axis_arst) begin
         state     <= IDLE;
         beat_idx  <= '0;
         pkt_count <= '0;
      end else begin
         state     <= state_next;
         beat_idx  <= beat_next;
         pkt_count <= pkt_count + CNT_W'(pkt_inc);
      end
   end

`ifdef AXIS_SLAVE_LEN_CHECK_EN
   always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
      if (s_axis_arst) begin
         len_err   <= 1'b0;
         err_count <= '0;
      end else begin
         len_err   <= err_set;
         err_count <= err_count + CNT_W'(err_set);
      end
   end
`else
   assign len_err   = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_axis_slave.sv
// Bench for axis_slave: randomized and directed stream traffic against a queue-based packet model.
// Builds in either configuration of AXIS_SLAVE_LEN_CHECK_EN.
module tb_axis_slave;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 8;
   localparam int PKT_LEN = 4;
   localparam int CNT_W   = 16;
   localparam int BW      = $clog2(PKT_LEN+1);
   localparam int BMAX    = (1 << BW) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] s_axis_tdata = '0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tlast = 1'b0;
   logic              s_axis_tready;
   logic [DATA_W-1:0] data_out;
   logic              data_last;
   logic              data_valid;
   logic              data_ready = 1'b0;
   logic [CNT_W-1:0]  pkt_count;
   logic [BW-1:0]     beat_idx;
   logic              len_err;
   logic [CNT_W-1:0]  err_count;

   axis_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
      .s_axis_aclk  (clk),
      .s_axis_arst  (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .data_out     (data_out),
      .data_last    (data_last),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .pkt_count    (pkt_count),
      .beat_idx     (beat_idx),
      .len_err      (len_err),
      .err_count    (err_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [DATA_W:0]  exp_q[$];
   logic             exp_ready   = 1'b0;
   logic             exp_len_err = 1'b0;
   logic [CNT_W-1:0] exp_pkt     = '0;
   logic [CNT_W-1:0] exp_err     = '0;
   int               cur_len     = 0;
   logic             push_pend   = 1'b0;
   logic [DATA_W:0]  pend_item   = '0;
   logic             rnd_done    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_ready   = 1'b0;
      exp_len_err = 1'b0;
      exp_pkt     = '0;
      exp_err     = '0;
      cur_len     = 0;
   endtask

   task automatic model_beat(input logic last);
      cur_len++;
`ifdef AXIS_SLAVE_LEN_CHECK_EN
      if (last || cur_len == PKT_LEN) begin
         if (last && cur_len == PKT_LEN) exp_pkt++;
         else begin
            exp_err++;
            exp_len_err = 1'b1;
         end
         cur_len = 0;
      end
`else
      if (last) begin
         exp_pkt++;
         cur_len = 0;
      end
`endif
   endtask

   function automatic logic [31:0] exp_beat();
      return (cur_len > BMAX) ? BMAX : cur_len;
   endfunction

   // model: observe the stream handshake mid-cycle, apply it after the edge
   always @(negedge clk) begin
      push_pend = !rst && s_axis_tvalid && exp_ready;
      pend_item = {s_axis_tlast, s_axis_tdata};
   end

   always @(posedge clk) begin
      #1;
      if (rst) model_clear();
      else begin
         exp_len_err = 1'b0;
         if (push_pend) begin
            exp_q.push_back(pend_item);
            model_beat(pend_item[DATA_W]);
         end
         exp_ready = (exp_q.size() < DEPTH);
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [DATA_W:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("tready",     32'(s_axis_tready), 32'(exp_ready));
      chk("data_valid", 32'(data_valid),    32'(exp_q.size() != 0));
      chk("head",       32'({data_last, data_out}), 32'(head));
      chk("pkt_count",  32'(pkt_count),     32'(exp_pkt));
      chk("beat_idx",   32'(beat_idx),      exp_beat());
      chk("len_err",    32'(len_err),       32'(exp_len_err));
      chk("err_count",  32'(err_count),     32'(exp_err));
      if (data_valid && data_ready && exp_q.size() > 0) void'(exp_q.pop_front());
   end

   // driver tasks (entered and left at posedge + 2)
   task automatic idle(input int n);
      repeat (n) begin
         s_axis_tdata = DATA_W'($urandom);
         s_axis_tlast = 1'($urandom);
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
      bit done;
      done = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         done = s_axis_tready;
         @(posedge clk);
         #2;
      end
      s_axis_tvalid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept expected=accept data=%0h at %0t", d, $time);
      end
   endtask

   task automatic do_reset_async();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_tready",    32'(s_axis_tready), 0);
      chk("async_data_valid", 32'(data_valid),   0);
      chk("async_data_out",  32'({data_last, data_out}), 0);
      chk("async_pkt_count", 32'(pkt_count),     0);
      chk("async_beat_idx",  32'(beat_idx),      0);
      chk("async_err",       32'({len_err, err_count}), 0);
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset held 3 cycles then released
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("t1_tready_after_release", 32'(s_axis_tready), 1);
      idle(1);

      // 2: one well-formed packet straight through
      data_ready = 1'b1;
      send_beat(8'd0, 1'b0);
      send_beat(8'd5, 1'b0);
      send_beat(8'd10, 1'b0);
      send_beat(8'd15, 1'b1);
      idle(4);
      chk("t2_pkt_count", 32'(pkt_count), 1);
      chk("t2_beat_idx",  32'(beat_idx), 0);

      // 3/4: fill with consumer stalled, pop one while ninth beat is offered
      data_ready = 1'b0;
      fork
         for (int i = 0; i < 9; i++) send_beat(DATA_W'(100 + i), (i % 4) == 3);
         begin
            repeat (11) @(posedge clk);
            #2;
            chk("t3_full_tready", 32'(s_axis_tready), 0);
            repeat (3) @(posedge clk);
            #2;
            data_ready = 1'b1;
            @(posedge clk);
            #2;
            data_ready = 1'b0;
         end
      join
      idle(3);
      data_ready = 1'b1;
      idle(12);

      // 4: half full, then streaming with simultaneous push and pop
      data_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(DATA_W'(200 + i), 1'b0);
      data_ready = 1'b1;
      for (int i = 0; i < 6; i++) send_beat(DATA_W'(210 + i), i == 5);
      idle(10);

      // 5: short packet, long run without tlast, saturation of beat_idx
      send_beat(8'h31, 1'b0);
      send_beat(8'h32, 1'b0);
      send_beat(8'h33, 1'b1);
      idle(2);
      for (int i = 0; i < 5; i++) send_beat(DATA_W'(8'h40 + i), 1'b0);
      send_beat(8'h4f, 1'b1);
      for (int i = 0; i < 9; i++) send_beat(DATA_W'(8'h50 + i), 1'b0);
      send_beat(8'h5f, 1'b1);
      idle(4);

      // 6: async reset after beat 2 of a packet, then a fresh packet
      data_ready = 1'b0;
      send_beat(8'h61, 1'b0);
      send_beat(8'h62, 1'b0);
      do_reset_async();
      data_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(DATA_W'(8'h70 + i), i == 3);
      idle(4);
      chk("t6_pkt_count", 32'(pkt_count), 1);

      // randomized traffic with random consumer back-pressure
      fork
         begin
            for (int p = 0; p < 40; p++) begin
               int len;
`ifdef AXIS_SLAVE_LEN_CHECK_EN
               len = $urandom_range(1, PKT_LEN + 2);
`else
               len = $urandom_range(1, 10);
`endif
               for (int b = 0; b < len; b++) begin
                  send_beat(DATA_W'($urandom), (b == len - 1) && ($urandom_range(0, 4) != 0));
                  if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #2;
               data_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      data_ready = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
